myriadrf_usb_packer: RTL and testbench
======================================

MYRIADRF_USB_PACKER -- requirements
Module: myriadrf_usb_packer

Interface
REQ-001 Parameter PKT_WORDS, 256: 16-bit words per USB packet (range 2..65535).
REQ-002 Parameter TIMEOUT, 1024: idle cycles before a partial packet is flushed (range 2..65535).
REQ-003 wb_clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 wb_rst  in  1  reset, synchronous, active-high.
REQ-005 enable_i  in  1  packing enable; low blocks input acceptance only.
REQ-006 s_data_i  in  24  IQ sample from the RX chain USB stream.
REQ-007 s_valid_i  in  1  sample valid.
REQ-008 s_ready_o  out  1  sample accepted when s_valid_i and s_ready_o are both high.
REQ-009 m_data_o  out  16  packed word to USB slave FIFO writer.
REQ-010 m_valid_o  out  1  word valid.
REQ-011 m_last_o  out  1  final word of packet; qualified by m_valid_o.
REQ-012 m_ready_i  in  1  downstream accepts word when m_valid_o and m_ready_i are both high.
REQ-013 pkt_count_o  out  16  completed packets, wraps 0xFFFF -> 0x0000.

Function
REQ-014 Output stage SHALL be one register: m_data_o/m_valid_o/m_last_o load only when "slot free" = !m_valid_o || m_ready_i.
REQ-015 Gearbox phase register SHALL hold P0 (no residue), P1 (8-bit residue), P2 (16-bit residue).
REQ-016 s_ready_o SHALL = enable_i && phase!=P2 && slot free && !flush_pend; combinational from m_ready_i is permitted.
REQ-017 P0, sample A accepted: load word A[15:0], residue <= A[23:16], go P1.
REQ-018 P1, sample B accepted: load word {B[7:0], residue[7:0]}, residue <= B[23:8], go P2.
REQ-019 P2, slot free and no flush pending: load word residue[15:0], go P0; consumes no input.
REQ-020 Latency sample accept -> word visible on m_data_o SHALL be 1 cycle; throughput 3 words per 2 samples, 1 word/cycle sustained under continuous m_ready_i.
REQ-021 Word counter wcnt (16 bits) SHALL increment on each output handshake; m_last_o loaded high for the word that makes wcnt reach PKT_WORDS-1; that handshake clears wcnt to 0 and increments pkt_count_o.
REQ-022 Packet boundaries SHALL be independent of gearbox phase; a sample may straddle two packets.
REQ-023 Idle counter SHALL clear on any output handshake or when s_valid_i is high, else increment, saturating at TIMEOUT.
REQ-024 Flush pending SHALL be set when idle counter == TIMEOUT and (wcnt != 0 or phase != P0 or m_valid_o high) and no flush already issued since last handshake.
REQ-025 Flush word, loaded when slot free: P1 -> {8'h00, residue[7:0]}; P2 -> residue[15:0]; P0 -> 16'h0000 pad; m_last_o high; phase <= P0; flush pending clears; packet completes per REQ-021 on its handshake (wcnt cleared, pkt_count_o incremented).
REQ-026 If a pending (not yet accepted) word already exists when flush fires, flush word SHALL follow it; no word is dropped or overwritten.
REQ-027 Flush SHALL NOT fire when wcnt==0, phase==P0 and output empty (nothing buffered).
REQ-028 enable_i low SHALL not discard residue; P2 residue still drains; flush still operates.
REQ-029 No data loss: every accepted sample bit SHALL appear in exactly one output word.

Reset
REQ-030 On wb_rst high at a clock edge: m_valid_o=0, m_last_o=0, m_data_o=0, phase=P0, residue=0, wcnt=0, idle=0, flush pending=0, pkt_count_o=0; s_ready_o=0 while wb_rst high.
REQ-031 Reset mid-packet SHALL discard residue and pending word; first post-reset sample starts a new packet in P0.

Verification
REQ-032 Samples 0xABC123, 0xDEF456, m_ready_i=1 -> words 0xC123, 0x56AB, 0xDEF4; s_ready_o low on the P2 cycle.
REQ-033 PKT_WORDS=6, 4 samples continuous -> 6 words, m_last_o only on 6th, pkt_count_o 0->1, wcnt returns 0.
REQ-034 m_ready_i toggled pseudo-randomly over 3000 samples -> output word stream equals reference packing bit-exact, no gaps or duplicates.
REQ-035 TIMEOUT=16, single sample 0x123456 then idle -> 0x3456, then after 16 idle cycles 0x0012 with m_last_o=1, pkt_count_o=1.
REQ-036 wb_rst asserted in P1 with m_valid_o=1 and m_ready_i=0 -> next cycle all outputs 0, next sample 0x000FFF yields 0x0FFF.
REQ-037 pkt_count_o at 0xFFFF, one more packet -> 0x0000.

Source files
------------

// File: rtl/myriadrf_usb_packer.sv
// Packs 24-bit IQ samples into a 16-bit USB word stream (3 words per 2 samples),
// framing fixed-size packets and flushing partial packets after an idle timeout.
module myriadrf_usb_packer #(
   parameter int PKT_WORDS = 256,
   parameter int TIMEOUT   = 1024
) (
   input  logic        wb_clk,
   input  logic        wb_rst,
   input  logic        enable_i,
   input  logic [23:0] s_data_i,
   input  logic        s_valid_i,
   output logic        s_ready_o,
   output logic [15:0] m_data_o,
   output logic        m_valid_o,
   output logic        m_last_o,
   input  logic        m_ready_i,
   output logic [15:0] pkt_count_o
);

   typedef enum logic [1:0] {P0, P1, P2} phase_e;

   localparam logic [15:0] LAST_IDX = 16'(PKT_WORDS - 1);
   localparam logic [15:0] IDLE_MAX = 16'(TIMEOUT);

   phase_e      phase_q, phase_d;
   logic [15:0] residue_q, residue_d;
   logic [15:0] m_data_q, m_data_d;
   logic        m_valid_q, m_valid_d;
   logic        m_last_q, m_last_d;
   logic [15:0] wcnt_q, wcnt_d;
   logic [15:0] pkt_q, pkt_d;
   logic [15:0] idle_q, idle_d;
   logic        flush_pend_q, flush_pend_d;
   logic        flush_done_q, flush_done_d;

   logic        slot_free;
   logic        out_hs;
   logic        accept;
   logic [15:0] load_idx;

   assign slot_free = !m_valid_q || m_ready_i;
   assign out_hs    = m_valid_q && m_ready_i;
   assign s_ready_o = !wb_rst && enable_i && (phase_q != P2) && slot_free && !flush_pend_q;
   assign accept    = s_valid_i && s_ready_o;

   // Packet position of a word loaded this cycle, accounting for the word leaving now.
   assign load_idx = out_hs ? (m_last_q ? 16'd0 : 16'(wcnt_q + 16'd1)) : wcnt_q;

   always_comb begin
      phase_d      = phase_q;
      residue_d    = residue_q;
      m_data_d     = m_data_q;
      m_valid_d    = m_valid_q;
      m_last_d     = m_last_q;
      wcnt_d       = wcnt_q;
      pkt_d        = pkt_q;
      idle_d       = idle_q;
      flush_pend_d = flush_pend_q;
      flush_done_d = flush_done_q;

      if (out_hs) begin
         m_valid_d    = 1'b0;
         m_last_d     = 1'b0;
         flush_done_d = 1'b0;
         if (m_last_q) begin
            wcnt_d = 16'd0;
            pkt_d  = 16'(pkt_q + 16'd1);
         end else begin
            wcnt_d = 16'(wcnt_q + 16'd1);
         end
      end

      if (flush_pend_q && slot_free) begin
         unique case (phase_q)
            P1:      m_data_d = {8'h00, residue_q[7:0]};
            P2:      m_data_d = residue_q;
            default: m_data_d = 16'h0000;
         endcase
         m_valid_d    = 1'b1;
         m_last_d     = 1'b1;
         phase_d      = P0;
         residue_d    = 16'h0000;
         flush_pend_d = 1'b0;
         flush_done_d = 1'b1;
      end else if (phase_q == P2 && slot_free) begin
         m_data_d  = residue_q;
         m_valid_d = 1'b1;
         m_last_d  = (load_idx == LAST_IDX);
         phase_d   = P0;
      end else if (accept) begin
         m_valid_d = 1'b1;
         m_last_d  = (load_idx == LAST_IDX);
         if (phase_q == P0) begin
            m_data_d  = s_data_i[15:0];
            residue_d = {8'h00, s_data_i[23:16]};
            phase_d   = P1;
         end else begin
            m_data_d  = {s_data_i[7:0], residue_q[7:0]};
            residue_d = s_data_i[23:8];
            phase_d   = P2;
         end
      end

      if (out_hs || s_valid_i) begin
         idle_d = 16'd0;
      end else if (idle_q != IDLE_MAX) begin
         idle_d = 16'(idle_q + 16'd1);
      end

      // One flush per quiet period, and only when something is actually buffered.
      if (!flush_pend_q && !flush_done_q && idle_q == IDLE_MAX &&
          (wcnt_q != 16'd0 || phase_q != P0 || m_valid_q)) begin
         flush_pend_d = 1'b1;
      end
   end

   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         phase_q      <= P0;
         residue_q    <= 16'h0000;
         m_data_q     <= 16'h0000;
         m_valid_q    <= 1'b0;
         m_last_q     <= 1'b0;
         wcnt_q       <= 16'd0;
         pkt_q        <= 16'd0;
         idle_q       <= 16'd0;
         flush_pend_q <= 1'b0;
         flush_done_q <= 1'b0;
      end else begin
         phase_q      <= phase_d;
         residue_q    <= residue_d;
         m_data_q     <= m_data_d;
         m_valid_q    <= m_valid_d;
         m_last_q     <= m_last_d;
         wcnt_q       <= wcnt_d;
         pkt_q        <= pkt_d;
         idle_q       <= idle_d;
         flush_pend_q <= flush_pend_d;
         flush_done_q <= flush_done_d;
      end
   end

   assign m_data_o    = m_data_q;
   assign m_valid_o   = m_valid_q;
   assign m_last_o    = m_last_q;
   assign pkt_count_o = pkt_q;

endmodule

// File: tb/tb_myriadrf_usb_packer.sv
// Scoreboard bench for myriadrf_usb_packer: stimulus pushes expected words,
// a negedge monitor pops and compares on every output handshake.
module tb_myriadrf_usb_packer;

   localparam int PKT = 6;
   localparam int TO  = 16;

   logic        wb_clk = 1'b0;
   logic        wb_rst = 1'b1;
   logic        enable_i = 1'b1;
   logic [23:0] s_data_i = 24'h0;
   logic        s_valid_i = 1'b0;
   logic        s_ready_o;
   logic [15:0] m_data_o;
   logic        m_valid_o;
   logic        m_last_o;
   logic        m_ready_i = 1'b1;
   logic [15:0] pkt_count_o;

   int tests = 0;
   int fails = 0;
   logic [16:0] exp_q[$];
   logic [15:0] exp_pkt = 16'd0;
   logic rnd_mode = 1'b0;
   logic rdy_force = 1'b1;

   logic [47:0] acc;
   int nbits;
   int wcnt_m;

   myriadrf_usb_packer #(.PKT_WORDS(PKT), .TIMEOUT(TO)) dut (
      .wb_clk(wb_clk), .wb_rst(wb_rst), .enable_i(enable_i),
      .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
      .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_last_o(m_last_o),
      .m_ready_i(m_ready_i), .pkt_count_o(pkt_count_o)
   );

   always #5 wb_clk = ~wb_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   always begin
      @(posedge wb_clk);
      #1;
      m_ready_i = rnd_mode ? 1'($urandom_range(0, 1)) : rdy_force;
   end

   always @(negedge wb_clk) begin
      if (wb_rst) begin
         exp_pkt = 16'd0;
      end else if (m_valid_o && m_ready_i) begin
         check("pkt_count", {16'h0, pkt_count_o}, {16'h0, exp_pkt});
         if (exp_q.size() == 0) begin
            check("unexpected_word", {15'h0, m_last_o, m_data_o}, 32'hFFFF_FFFF);
         end else begin
            logic [16:0] e;
            e = exp_q.pop_front();
            check("word", {15'h0, m_last_o, m_data_o}, {15'h0, e});
            $display("[TB] word %h last %0d", m_data_o, m_last_o);
         end
         if (m_last_o) exp_pkt = 16'(exp_pkt + 16'd1);
      end
   end

   task automatic expect_word(input logic [15:0] d, input logic last);
      exp_q.push_back({last, d});
   endtask

   task automatic send_raw(input logic [23:0] s);
      int n;
      logic ok;
      s_data_i = s;
      s_valid_i = 1'b1;
      ok = 1'b0;
      n = 0;
      while (!ok && n < 500) begin
         @(negedge wb_clk);
         ok = s_ready_o;
         @(posedge wb_clk);
         n++;
      end
      #1;
      s_valid_i = 1'b0;
      if (!ok) check("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic model_emit(input logic [15:0] d, input logic last);
      expect_word(d, last);
      wcnt_m = last ? 0 : wcnt_m + 1;
   endtask

   task automatic model_push(input logic [23:0] s);
      acc = acc | (48'(s) << nbits);
      nbits += 24;
      while (nbits >= 16) begin
         model_emit(acc[15:0], wcnt_m == PKT - 1);
         acc = acc >> 16;
         nbits -= 16;
      end
   endtask

   task automatic model_flush();
      if (nbits != 0 || wcnt_m != 0) model_emit(acc[15:0], 1'b1);
      acc = 48'h0;
      nbits = 0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge wb_clk);
      #1;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(posedge wb_clk);
         n++;
      end
      #1;
      check(name, exp_q.size(), 32'd0);
   endtask

   initial begin
      acc = 48'h0;
      nbits = 0;
      wcnt_m = 0;

      // Reset state
      cycles(2);
      @(negedge wb_clk);
      check("rst_s_ready", {31'h0, s_ready_o}, 32'd0);
      @(posedge wb_clk); #1;
      wb_rst = 1'b0;
      @(negedge wb_clk);
      check("rst_m_valid", {31'h0, m_valid_o}, 32'd0);
      check("rst_m_last", {31'h0, m_last_o}, 32'd0);
      check("rst_m_data", {16'h0, m_data_o}, 32'd0);
      check("rst_pkt", {16'h0, pkt_count_o}, 32'd0);
      @(posedge wb_clk); #1;

      // Basic packing; s_ready drops while the P2 residue drains
      expect_word(16'hC123, 1'b0);
      expect_word(16'h56AB, 1'b0);
      expect_word(16'hDEF4, 1'b0);
      send_raw(24'hABC123);
      send_raw(24'hDEF456);
      @(negedge wb_clk);
      check("p2_s_ready_low", {31'h0, s_ready_o}, 32'd0);
      @(posedge wb_clk); #1;
      @(negedge wb_clk);
      check("p0_s_ready_high", {31'h0, s_ready_o}, 32'd1);
      // Three words buffered in the packet -> timeout pads with an empty last word
      expect_word(16'h0000, 1'b1);
      cycles(40);
      drain("flush_pad_drain");
      check("pkt_after_pad", {16'h0, pkt_count_o}, 32'd1);

      // Exact packet of 6 words from 4 samples
      expect_word(16'h2030, 1'b0);
      expect_word(16'h6010, 1'b0);
      expect_word(16'h4050, 1'b0);
      expect_word(16'h8090, 1'b0);
      expect_word(16'hC070, 1'b0);
      expect_word(16'hA0B0, 1'b1);
      send_raw(24'h102030);
      send_raw(24'h405060);
      send_raw(24'h708090);
      send_raw(24'hA0B0C0);
      cycles(40);
      drain("full_pkt_drain");
      check("pkt_after_full", {16'h0, pkt_count_o}, 32'd2);

      // Single sample then idle: residue flushed after timeout
      expect_word(16'h3456, 1'b0);
      expect_word(16'h0012, 1'b1);
      send_raw(24'h123456);
      cycles(40);
      drain("timeout_drain");
      check("pkt_after_timeout", {16'h0, pkt_count_o}, 32'd3);

      // Enable low holds input off but residue is kept and still flushed
      expect_word(16'hAA55, 1'b0);
      expect_word(16'h0077, 1'b1);
      send_raw(24'h77AA55);
      enable_i = 1'b0;
      s_valid_i = 1'b1;
      s_data_i = 24'hFFFFFF;
      repeat (30) begin
         @(negedge wb_clk);
         check("disabled_s_ready", {31'h0, s_ready_o}, 32'd0);
      end
      @(posedge wb_clk); #1;
      s_valid_i = 1'b0;
      cycles(40);
      drain("disabled_flush_drain");
      enable_i = 1'b1;

      // Reset in P1 with a stalled output word
      rdy_force = 1'b0;
      cycles(2);
      send_raw(24'hABCDEF);
      @(negedge wb_clk);
      check("stall_valid", {31'h0, m_valid_o}, 32'd1);
      @(posedge wb_clk); #1;
      wb_rst = 1'b1;
      @(posedge wb_clk); #1;
      wb_rst = 1'b0;
      @(negedge wb_clk);
      check("mid_rst_valid", {31'h0, m_valid_o}, 32'd0);
      check("mid_rst_data", {16'h0, m_data_o}, 32'd0);
      check("mid_rst_last", {31'h0, m_last_o}, 32'd0);
      check("mid_rst_pkt", {16'h0, pkt_count_o}, 32'd0);
      rdy_force = 1'b1;
      cycles(2);
      expect_word(16'h0FFF, 1'b0);
      expect_word(16'h0000, 1'b1);
      send_raw(24'h000FFF);
      cycles(40);
      drain("post_rst_drain");
      check("pkt_post_rst", {16'h0, pkt_count_o}, 32'd1);

      // Random backpressure over a long stream, checked against a bit-level reference
      acc = 48'h0;
      nbits = 0;
      wcnt_m = 0;
      rnd_mode = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         logic [23:0] s;
         s = 24'($urandom);
         model_push(s);
         send_raw(s);
         if ($urandom_range(0, 3) == 0) cycles($urandom_range(1, 2));
      end
      rnd_mode = 1'b0;
      rdy_force = 1'b1;
      model_flush();
      cycles(60);
      drain("random_drain");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
